// File: rtl/ropuf_meas_scheduler_if.sv
// Bundle between the RO-PUF measurement scheduler and its environment
// (key-generation control plus the RO array with its edge counters).
// master = environment side, slave = scheduler side.
interface ropuf_meas_scheduler_if #(
    parameter int N_BITS = 16,
    parameter int SEL_W  = 5,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              ro_en;
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic              cnt_clear;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [N_BITS-1:0] response;
    logic [N_BITS-1:0] unstable;

    modport master (
        output start, abort, cnt_a, cnt_b,
        input  busy, done, ro_en, sel_a, sel_b, cnt_clear, cnt_en, response, unstable
    );

    modport slave (
        input  start, abort, cnt_a, cnt_b,
        output busy, done, ro_en, sel_a, sel_b, cnt_clear, cnt_en, response, unstable
    );
endinterface

// File: rtl/ropuf_meas_scheduler.sv
// RO-PUF measurement scheduler: walks N_BITS RO pairs, gates the external
// edge counters for a fixed window and turns each count pair into a
// response bit plus a stability flag. All timing from one down-counter.
module ropuf_meas_scheduler #(
    parameter int N_BITS  = 16,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 16,
    parameter int SETTLE  = 8,
    parameter int WINDOW  = 1024,
    parameter int CAP_DLY = 2,
    parameter int MARGIN  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ropuf_meas_scheduler_if.slave bus
);
    localparam int TMAX = (SETTLE > WINDOW) ? ((SETTLE > CAP_DLY) ? SETTLE : CAP_DLY)
                                            : ((WINDOW > CAP_DLY) ? WINDOW : CAP_DLY);
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CNT_W:0] MARGIN_V = (CNT_W+1)'(MARGIN);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SETTLE, S_COUNT, S_HOLD, S_CAPTURE, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_ld;
    logic              tmr_zero;
    logic [IDX_W-1:0]  bit_idx, idx_inc;
    logic              last_bit;
    logic [SEL_W-1:0]  sel_a_q, sel_b_q;
    logic [N_BITS-1:0] resp_q, unst_q;
    logic [CNT_W:0]    diff, diff_abs;
    logic              a_gt_b, too_close;

    assign tmr_zero = (timer == '0);
    assign idx_inc  = bit_idx + 1'b1;
    assign last_bit = (bit_idx == IDX_W'(N_BITS - 1));

    // Count comparison: widened difference, magnitude checked against MARGIN.
    assign diff      = {1'b0, bus.cnt_a} - {1'b0, bus.cnt_b};
    assign diff_abs  = diff[CNT_W] ? (~diff + 1'b1) : diff;
    assign too_close = (diff_abs < MARGIN_V);
    assign a_gt_b    = (bus.cnt_a > bus.cnt_b);

    // Timer reload value for the state being entered; stages are 1-based counts.
    always_comb begin
        timer_ld = '0;
        case (state_nxt)
            S_SETTLE: timer_ld = TMR_W'(SETTLE - 1);
            S_COUNT:  timer_ld = TMR_W'(WINDOW - 1);
            S_HOLD:   timer_ld = TMR_W'(CAP_DLY - 1);
            default:  timer_ld = '0;
        endcase
    end

    // State register and shared down-counter (reloaded on every state change).
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                timer <= timer_ld;
            else if (!tmr_zero)
                timer <= timer - 1'b1;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.start && !bus.abort) state_nxt = S_SETUP;
            S_SETUP:   state_nxt = S_SETTLE;
            S_SETTLE:  if (tmr_zero) state_nxt = S_COUNT;
            S_COUNT:   if (tmr_zero) state_nxt = S_HOLD;
            S_HOLD:    if (tmr_zero) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = last_bit ? S_DONE : S_SETUP;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (bus.abort && state != S_IDLE)
            state_nxt = S_IDLE;
    end

    // Moore control outputs decoded from the current state.
    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.ro_en     = 1'b0;
        bus.cnt_clear = 1'b0;
        bus.cnt_en    = 1'b0;
        case (state)
            S_SETUP: begin
                bus.busy      = 1'b1;
                bus.ro_en     = 1'b1;
                bus.cnt_clear = 1'b1;
            end
            S_SETTLE, S_HOLD, S_CAPTURE: begin
                bus.busy  = 1'b1;
                bus.ro_en = 1'b1;
            end
            S_COUNT: begin
                bus.busy   = 1'b1;
                bus.ro_en  = 1'b1;
                bus.cnt_en = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Pair index, selects and result registers; selects are loaded as SETUP
    // is entered so they are valid during SETUP and hold afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            resp_q  <= '0;
            unst_q  <= '0;
        end else begin
            if (state == S_IDLE && state_nxt == S_SETUP) begin
                bit_idx <= '0;
                resp_q  <= '0;
                unst_q  <= '0;
                sel_a_q <= SEL_W'(0);
                sel_b_q <= SEL_W'(1);
            end
            if (state == S_CAPTURE) begin
                resp_q[bit_idx] <= a_gt_b;
                unst_q[bit_idx] <= too_close;
                if (state_nxt == S_SETUP) begin
                    bit_idx <= idx_inc;
                    sel_a_q <= SEL_W'({idx_inc, 1'b0});
                    sel_b_q <= SEL_W'({idx_inc, 1'b1});
                end
            end
        end
    end

    assign bus.sel_a    = sel_a_q;
    assign bus.sel_b    = sel_b_q;
    assign bus.response = resp_q;
    assign bus.unstable = unst_q;
endmodule

// File: tb/tb_ropuf_meas_scheduler.sv
// Directed bench for ropuf_meas_scheduler: table-driven count vectors plus
// hand-written abort, restart, reset and cycle-timing sequences.
module tb_ropuf_meas_scheduler;
    localparam int N_BITS  = 4;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 16;
    localparam int SETTLE  = 2;
    localparam int WINDOW  = 16;
    localparam int CAP_DLY = 2;
    localparam int MARGIN  = 4;
    localparam int PER_BIT = SETTLE + WINDOW + CAP_DLY + 2;   // 22
    localparam int DONE_AT = 1 + N_BITS * PER_BIT;            // 89

    typedef struct {
        logic [CNT_W-1:0] a;
        logic [CNT_W-1:0] b;
        logic             resp;
        logic             unst;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   done_cyc;
    int   n_done;
    vec_t vecs [0:7];
    logic [CNT_W-1:0] tbl_a [0:N_BITS-1];
    logic [CNT_W-1:0] tbl_b [0:N_BITS-1];

    always #5 clk = ~clk;

    ropuf_meas_scheduler_if #(.N_BITS(N_BITS), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    ropuf_meas_scheduler #(
        .N_BITS(N_BITS), .SEL_W(SEL_W), .CNT_W(CNT_W), .SETTLE(SETTLE),
        .WINDOW(WINDOW), .CAP_DLY(CAP_DLY), .MARGIN(MARGIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    // Edge-counter model: present the stored counts for the selected pair.
    always_comb begin
        bus.cnt_a = tbl_a[bus.sel_a[SEL_W-1:1]];
        bus.cnt_b = tbl_b[bus.sel_a[SEL_W-1:1]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"},      32'(bus.busy),      0);
        chk({tag, " done"},      32'(bus.done),      0);
        chk({tag, " ro_en"},     32'(bus.ro_en),     0);
        chk({tag, " cnt_en"},    32'(bus.cnt_en),    0);
        chk({tag, " cnt_clear"}, 32'(bus.cnt_clear), 0);
        chk({tag, " sel_a"},     32'(bus.sel_a),     0);
        chk({tag, " sel_b"},     32'(bus.sel_b),     0);
        chk({tag, " response"},  32'(bus.response),  0);
        chk({tag, " unstable"},  32'(bus.unstable),  0);
    endtask

    // Expected control outputs for cycle c after the start-sampling edge.
    task automatic chk_cycle(input int c);
        int b, ph;
        logic busy_e, done_e, ro_e, clr_e, en_e;
        int sa_e, sb_e;
        busy_e = 0; done_e = 0; ro_e = 0; clr_e = 0; en_e = 0;
        sa_e = 2 * (N_BITS - 1); sb_e = sa_e + 1;
        if (c >= 1 && c < DONE_AT) begin
            b  = (c - 1) / PER_BIT;
            ph = (c - 1) % PER_BIT;
            busy_e = 1; ro_e = 1;
            clr_e  = (ph == 0);
            en_e   = (ph >= 1 + SETTLE) && (ph < 1 + SETTLE + WINDOW);
            sa_e   = 2 * b; sb_e = 2 * b + 1;
        end else if (c == DONE_AT) begin
            done_e = 1;
        end
        chk($sformatf("busy@%0d", c),      32'(bus.busy),      32'(busy_e));
        chk($sformatf("done@%0d", c),      32'(bus.done),      32'(done_e));
        chk($sformatf("ro_en@%0d", c),     32'(bus.ro_en),     32'(ro_e));
        chk($sformatf("cnt_clear@%0d", c), 32'(bus.cnt_clear), 32'(clr_e));
        chk($sformatf("cnt_en@%0d", c),    32'(bus.cnt_en),    32'(en_e));
        chk($sformatf("sel_a@%0d", c),     32'(bus.sel_a),     32'(sa_e));
        chk($sformatf("sel_b@%0d", c),     32'(bus.sel_b),     32'(sb_e));
    endtask

    // Start a run from a negedge and follow it to cycle 'last' (bounded).
    task automatic run_to(input int last, input bit seq_chk, input int again_at);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        done_cyc = 0;
        n_done   = 0;
        for (int c = 1; c <= last; c++) begin
            if (seq_chk) chk_cycle(c);
            if (bus.done === 1'b1) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c < last) begin
                bus.start = (c == again_at);
                step();
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic load(input int base);
        for (int i = 0; i < N_BITS; i++) begin
            tbl_a[i] = vecs[base + i].a;
            tbl_b[i] = vecs[base + i].b;
        end
    endtask

    initial begin
        logic [N_BITS-1:0] exp_r, exp_u;

        vecs[0] = '{16'd100,  16'd90,   1'b1, 1'b0};
        vecs[1] = '{16'd50,   16'd60,   1'b0, 1'b0};
        vecs[2] = '{16'd70,   16'd70,   1'b0, 1'b1};
        vecs[3] = '{16'd80,   16'd78,   1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h1003, 16'h1000, 1'b1, 1'b1};
        vecs[7] = '{16'h1004, 16'h1000, 1'b1, 1'b0};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        load(0);
        step(); step(); step();
        chk_all_zero("in_reset");
        reset = 1'b0;
        step();
        chk_all_zero("after_reset");

        // Normal runs: cycle-by-cycle sequencing on the first, count table on both.
        for (int r = 0; r < 2; r++) begin
            load(4 * r);
            run_to(95, (r == 0), -1);
            chk($sformatf("done_cycle run%0d", r), 32'(done_cyc), 32'(DONE_AT));
            chk($sformatf("done_pulses run%0d", r), 32'(n_done), 1);
            for (int i = 0; i < N_BITS; i++) begin
                chk($sformatf("response[%0d] vec%0d", i, 4 * r + i),
                    32'(bus.response[i]), 32'(vecs[4 * r + i].resp));
                chk($sformatf("unstable[%0d] vec%0d", i, 4 * r + i),
                    32'(bus.unstable[i]), 32'(vecs[4 * r + i].unst));
            end
        end

        // Restart request in bit 1 is ignored.
        load(0);
        run_to(95, 1'b0, 30);
        chk("restart done_cycle", 32'(done_cyc), 32'(DONE_AT));
        chk("restart done_pulses", 32'(n_done), 1);
        for (int i = 0; i < N_BITS; i++) exp_r[i] = vecs[i].resp;
        chk("restart response", 32'(bus.response), 32'(exp_r));

        // start with abort in IDLE: stays idle, results untouched.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("start_abort busy+%0d", k), 32'(bus.busy), 0);
            chk($sformatf("start_abort ro_en+%0d", k), 32'(bus.ro_en), 0);
            step();
        end
        chk("start_abort response", 32'(bus.response), 32'(exp_r));

        // Abort during bit 2 COUNT.
        run_to(50, 1'b0, -1);
        chk("pre_abort cnt_en", 32'(bus.cnt_en), 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort ro_en", 32'(bus.ro_en), 0);
        chk("abort cnt_en", 32'(bus.cnt_en), 0);
        chk("abort busy", 32'(bus.busy), 0);
        for (int k = 0; k < 50; k++) begin
            if (bus.done === 1'b1) n_done++;
            step();
        end
        chk("abort done_pulses", 32'(n_done), 0);
        exp_r = '0; exp_u = '0;
        for (int i = 0; i < 2; i++) begin
            exp_r[i] = vecs[i].resp;
            exp_u[i] = vecs[i].unst;
        end
        chk("abort response", 32'(bus.response), 32'(exp_r));
        chk("abort unstable", 32'(bus.unstable), 32'(exp_u));

        // Synchronous reset in bit 3 HOLD.
        run_to(86, 1'b0, -1);
        reset = 1'b1;
        #1;
        chk("reset_no_edge busy", 32'(bus.busy), 1);
        chk("reset_no_edge ro_en", 32'(bus.ro_en), 1);
        chk("reset_no_edge sel_a", 32'(bus.sel_a), 6);
        chk("reset_no_edge response", 32'(bus.response), 32'(4'b0001));
        step();
        chk_all_zero("reset_mid_run");
        reset = 1'b0;
        step();
        chk_all_zero("reset_released");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
